// File: rtl/decode_pkg.sv
// Shared decoder encodings: opcode maps, prefix fields, prefix byte values and
// the registered header handed to the opcode info tables.
package decode_pkg;

  typedef enum logic [1:0] {MAP_1B, MAP_0F, MAP_0F38, MAP_0F3A} map_e;
  typedef enum logic [1:0] {REP_NONE, REP_F3, REP_F2} rep_e;
  typedef enum logic [2:0] {SEG_NONE, SEG_ES, SEG_CS, SEG_SS, SEG_DS, SEG_FS, SEG_GS} seg_e;

  localparam int MAX_LEN_DEFAULT = 15;

  localparam logic [7:0] PFX_OPSZ = 8'h66;
  localparam logic [7:0] PFX_ADSZ = 8'h67;
  localparam logic [7:0] PFX_LOCK = 8'hF0;
  localparam logic [7:0] PFX_REPE = 8'hF3;
  localparam logic [7:0] PFX_REPN = 8'hF2;
  localparam logic [7:0] PFX_ES   = 8'h26;
  localparam logic [7:0] PFX_CS   = 8'h2E;
  localparam logic [7:0] PFX_SS   = 8'h36;
  localparam logic [7:0] PFX_DS   = 8'h3E;
  localparam logic [7:0] PFX_FS   = 8'h64;
  localparam logic [7:0] PFX_GS   = 8'h65;
  localparam logic [7:0] ESC_0F   = 8'h0F;
  localparam logic [7:0] ESC_38   = 8'h38;
  localparam logic [7:0] ESC_3A   = 8'h3A;

  typedef struct packed {
    map_e       map;
    logic [7:0] opcode;
    logic [3:0] rex;
    logic       rex_present;
    logic       opsz;
    logic       adsz;
    logic       lock;
    rep_e       rep;
    seg_e       seg;
    logic [3:0] len;
    logic       err;
  } hdr_t;

endpackage

// File: rtl/opcode_prefix_parser_if.sv
// Byte-in / header-out handshake bundle of the prefix parser.
interface opcode_prefix_parser_if;
  logic       in_valid;
  logic [7:0] in_byte;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_map;
  logic [7:0] out_opcode;
  logic [3:0] out_rex;
  logic       out_rex_present;
  logic       out_opsz;
  logic       out_adsz;
  logic       out_lock;
  logic [1:0] out_rep;
  logic [2:0] out_seg;
  logic [3:0] out_len;
  logic       out_err;

  modport master (
    output in_valid, in_byte, out_ready,
    input  in_ready, out_valid, out_map, out_opcode, out_rex, out_rex_present,
           out_opsz, out_adsz, out_lock, out_rep, out_seg, out_len, out_err
  );

  modport slave (
    input  in_valid, in_byte, out_ready,
    output in_ready, out_valid, out_map, out_opcode, out_rex, out_rex_present,
           out_opsz, out_adsz, out_lock, out_rep, out_seg, out_len, out_err
  );
endinterface

// File: rtl/prefix_classify.sv
// Combinational byte classifier: legacy prefix, REX, 0F escape, and the
// prefix field each legacy byte selects.
module prefix_classify
  import decode_pkg::*;
(
  input  logic [7:0] b,
  output logic       is_legacy,
  output logic       is_rex,
  output logic       is_esc,
  output logic       is_opsz,
  output logic       is_adsz,
  output logic       is_lock,
  output rep_e       rep,
  output seg_e       seg
);
  always_comb begin
    is_opsz = 1'b0;
    is_adsz = 1'b0;
    is_lock = 1'b0;
    rep     = REP_NONE;
    seg     = SEG_NONE;
    case (b)
      PFX_OPSZ: is_opsz = 1'b1;
      PFX_ADSZ: is_adsz = 1'b1;
      PFX_LOCK: is_lock = 1'b1;
      PFX_REPE: rep = REP_F3;
      PFX_REPN: rep = REP_F2;
      PFX_ES:   seg = SEG_ES;
      PFX_CS:   seg = SEG_CS;
      PFX_SS:   seg = SEG_SS;
      PFX_DS:   seg = SEG_DS;
      PFX_FS:   seg = SEG_FS;
      PFX_GS:   seg = SEG_GS;
      default: ;
    endcase
    is_legacy = is_opsz || is_adsz || is_lock || (rep != REP_NONE) || (seg != SEG_NONE);
    is_rex    = (b[7:4] == 4'h4);
    is_esc    = (b == ESC_0F);
  end
endmodule

// File: rtl/opcode_prefix_parser.sv
// Byte-serial prefix/escape stripper: accumulates prefix state until an opcode
// byte completes, then holds a header until the consumer takes it.
module opcode_prefix_parser
  import decode_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  flush,
  opcode_prefix_parser_if.slave bus
);
  localparam logic [1:0] S_PFX  = 2'd0;
  localparam logic [1:0] S_ESC  = 2'd1;
  localparam logic [1:0] S_ESC3 = 2'd2;
  localparam logic [3:0] LEN_LIM = 4'(MAX_LEN);

  logic [1:0] state;
  logic [3:0] count, next_count;
  logic [3:0] rex;
  logic       rex_present, opsz, adsz, lock;
  rep_e       rep;
  seg_e       seg;
  map_e       map, cur_map;
  hdr_t       hdr;
  logic       out_valid;
  logic       accept, done, emit;

  logic c_legacy, c_rex, c_esc, c_opsz, c_adsz, c_lock;
  rep_e c_rep;
  seg_e c_seg;

  prefix_classify u_cls (
    .b(bus.in_byte), .is_legacy(c_legacy), .is_rex(c_rex), .is_esc(c_esc),
    .is_opsz(c_opsz), .is_adsz(c_adsz), .is_lock(c_lock), .rep(c_rep), .seg(c_seg)
  );

  assign bus.in_ready = (!out_valid || bus.out_ready) && !flush;
  assign accept       = bus.in_valid && bus.in_ready;
  assign next_count   = count + 4'd1;

  // Prefix bytes are only interpreted in S_PFX; after an escape everything but 38/3A is an opcode.
  always_comb begin
    cur_map = MAP_1B;
    done    = 1'b0;
    case (state)
      S_PFX: done = !(c_legacy || c_rex || c_esc);
      S_ESC: begin
        cur_map = MAP_0F;
        done    = !(bus.in_byte == ESC_38 || bus.in_byte == ESC_3A);
      end
      default: begin
        cur_map = map;
        done    = 1'b1;
      end
    endcase
  end

  // The length limit forces an erroring emit on a byte that would otherwise keep the parse open.
  assign emit = accept && (done || next_count == LEN_LIM);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_PFX; count <= '0; rex <= '0; rex_present <= 1'b0;
      opsz <= 1'b0; adsz <= 1'b0; lock <= 1'b0;
      rep <= REP_NONE; seg <= SEG_NONE; map <= MAP_1B;
    end else if (flush || emit) begin
      state <= S_PFX; count <= '0; rex <= '0; rex_present <= 1'b0;
      opsz <= 1'b0; adsz <= 1'b0; lock <= 1'b0;
      rep <= REP_NONE; seg <= SEG_NONE; map <= MAP_1B;
    end else if (accept) begin
      count <= next_count;
      case (state)
        S_PFX: begin
          if (c_legacy) begin
            opsz        <= opsz | c_opsz;
            adsz        <= adsz | c_adsz;
            lock        <= lock | c_lock;
            if (c_rep != REP_NONE) rep <= c_rep;
            if (c_seg != SEG_NONE) seg <= c_seg;
            rex         <= '0;
            rex_present <= 1'b0;
          end else if (c_rex) begin
            rex         <= bus.in_byte[3:0];
            rex_present <= 1'b1;
          end else begin
            state <= S_ESC;
          end
        end
        S_ESC: begin
          state <= S_ESC3;
          map   <= (bus.in_byte == ESC_38) ? MAP_0F38 : MAP_0F3A;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      hdr       <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      hdr       <= '0;
    end else if (emit) begin
      out_valid       <= 1'b1;
      hdr.map         <= cur_map;
      hdr.opcode      <= bus.in_byte;
      hdr.rex         <= rex;
      hdr.rex_present <= rex_present;
      hdr.opsz        <= opsz;
      hdr.adsz        <= adsz;
      hdr.lock        <= lock;
      hdr.rep         <= rep;
      hdr.seg         <= seg;
      hdr.len         <= next_count;
      hdr.err         <= !done;
    end else if (bus.out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign bus.out_valid       = out_valid;
  assign bus.out_map         = hdr.map;
  assign bus.out_opcode      = hdr.opcode;
  assign bus.out_rex         = hdr.rex;
  assign bus.out_rex_present = hdr.rex_present;
  assign bus.out_opsz        = hdr.opsz;
  assign bus.out_adsz        = hdr.adsz;
  assign bus.out_lock        = hdr.lock;
  assign bus.out_rep         = hdr.rep;
  assign bus.out_seg         = hdr.seg;
  assign bus.out_len         = hdr.len;
  assign bus.out_err         = hdr.err;
endmodule

// File: tb/tb_opcode_prefix_parser.sv
// Bench for opcode_prefix_parser: vector table streamed through a header
// scoreboard, plus hand-written backpressure and flush sequences.
module tb_opcode_prefix_parser;
  logic clk = 1'b0;
  logic reset_n;
  logic flush;
  always #5 clk = ~clk;

  opcode_prefix_parser_if bus();
  opcode_prefix_parser #(.MAX_LEN(15)) dut (.clk(clk), .reset_n(reset_n), .flush(flush), .bus(bus));

  typedef struct {
    int          n;
    logic [27:0] exp;
  } vec_t;

  int          tests = 0;
  int          fails = 0;
  logic [27:0] sb[$];
  logic [7:0]  pool[$];
  vec_t        vecs[$];

  function automatic logic [27:0] mk(logic [1:0] map, logic [7:0] op, logic [3:0] rex, logic rp,
                                     logic opsz, logic adsz, logic lock, logic [1:0] rep,
                                     logic [2:0] seg, logic [3:0] len, logic err);
    return {map, op, rex, rp, opsz, adsz, lock, rep, seg, len, err};
  endfunction

  function automatic logic [27:0] got_hdr();
    return {bus.out_map, bus.out_opcode, bus.out_rex, bus.out_rex_present, bus.out_opsz,
            bus.out_adsz, bus.out_lock, bus.out_rep, bus.out_seg, bus.out_len, bus.out_err};
  endfunction

  task automatic chk(string name, logic [31:0] got, logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Scoreboard pop on every header handshake.
  always @(negedge clk) begin
    if (reset_n && bus.out_valid && bus.out_ready) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL hdr_unexpected: got %h want none", got_hdr());
      end else begin
        logic [27:0] w;
        w = sb.pop_front();
        if (got_hdr() !== w) begin
          fails++;
          $display("FAIL hdr: got %h want %h", got_hdr(), w);
        end
      end
    end
  end

  // Called aligned 1 time unit after a rising edge; returns likewise after acceptance.
  task automatic send(logic [7:0] b);
    int t;
    bus.in_valid = 1'b1;
    bus.in_byte  = b;
    t = 0;
    @(negedge clk);
    while (!bus.in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) chk("in_ready_timeout", 32'(t), 32'd0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int p;
    logic [27:0] h90;
    reset_n = 1'b0; flush = 1'b0;
    bus.in_valid = 1'b0; bus.in_byte = 8'h00; bus.out_ready = 1'b1;

    #12;
    chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset_fields", 32'(got_hdr()), 32'd0);
    step();
    reset_n = 1'b1;
    #1;
    chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
    step();

    pool = {8'h90,
            8'h66, 8'h48, 8'h0F, 8'hAF,
            8'h48, 8'h66, 8'h01,
            8'hF3, 8'hF2, 8'h2E, 8'h0F, 8'h3A, 8'h0F,
            8'h67, 8'hF0, 8'h65, 8'h41, 8'h0F, 8'h38, 8'hF1,
            8'h0F, 8'h66,
            8'h26, 8'h36, 8'h3E, 8'h64, 8'hC3,
            8'h0F, 8'h0F};
    vecs.push_back('{1, mk(2'd0, 8'h90, 4'h0, 0, 0, 0, 0, 2'd0, 3'd0, 4'd1, 0)});
    vecs.push_back('{4, mk(2'd1, 8'hAF, 4'h8, 1, 1, 0, 0, 2'd0, 3'd0, 4'd4, 0)});
    vecs.push_back('{3, mk(2'd0, 8'h01, 4'h0, 0, 1, 0, 0, 2'd0, 3'd0, 4'd3, 0)});
    vecs.push_back('{6, mk(2'd3, 8'h0F, 4'h0, 0, 0, 0, 0, 2'd2, 3'd2, 4'd6, 0)});
    vecs.push_back('{7, mk(2'd2, 8'hF1, 4'h1, 1, 0, 1, 1, 2'd0, 3'd6, 4'd7, 0)});
    vecs.push_back('{2, mk(2'd1, 8'h66, 4'h0, 0, 0, 0, 0, 2'd0, 3'd0, 4'd2, 0)});
    vecs.push_back('{5, mk(2'd0, 8'hC3, 4'h0, 0, 0, 0, 0, 2'd0, 3'd5, 4'd5, 0)});
    vecs.push_back('{2, mk(2'd1, 8'h0F, 4'h0, 0, 0, 0, 0, 2'd0, 3'd0, 4'd2, 0)});
    // 14 prefixes + opcode fits exactly; 15 prefixes trips the limit.
    for (int i = 0; i < 14; i++) pool.push_back(8'h66);
    pool.push_back(8'h90);
    vecs.push_back('{15, mk(2'd0, 8'h90, 4'h0, 0, 1, 0, 0, 2'd0, 3'd0, 4'd15, 0)});
    for (int i = 0; i < 15; i++) pool.push_back(8'h66);
    vecs.push_back('{15, mk(2'd0, 8'h66, 4'h0, 0, 1, 0, 0, 2'd0, 3'd0, 4'd15, 1)});
    pool.push_back(8'h90);
    vecs.push_back('{1, mk(2'd0, 8'h90, 4'h0, 0, 0, 0, 0, 2'd0, 3'd0, 4'd1, 0)});

    p = 0;
    for (int v = 0; v < vecs.size(); v++) begin
      sb.push_back(vecs[v].exp);
      for (int k = 0; k < vecs[v].n; k++) begin
        send(pool[p]);
        p++;
      end
    end
    repeat (3) step();

    // Backpressure: header held, in_ready low, queued byte accepted back-to-back on release.
    h90 = mk(2'd0, 8'h90, 4'h0, 0, 0, 0, 0, 2'd0, 3'd0, 4'd1, 0);
    bus.out_ready = 1'b0;
    sb.push_back(h90);
    send(8'h90);
    sb.push_back(mk(2'd0, 8'hC3, 4'h0, 0, 0, 0, 0, 2'd0, 3'd0, 4'd1, 0));
    bus.in_valid = 1'b1;
    bus.in_byte  = 8'hC3;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("stall_out_valid", 32'(bus.out_valid), 32'd1);
      chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
      chk("stall_hdr", 32'(got_hdr()), 32'(h90));
      step();
    end
    bus.out_ready = 1'b1;
    step();
    bus.in_valid = 1'b0;
    repeat (3) step();

    // Flush with a partial 66 0F parse pending.
    send(8'h66);
    send(8'h0F);
    flush = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_byte  = 8'h90;
    #1;
    chk("flush_in_ready", 32'(bus.in_ready), 32'd0);
    step();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
    step();
    sb.push_back(h90);
    send(8'h90);
    repeat (2) step();

    // Flush discarding a held header.
    bus.out_ready = 1'b0;
    send(8'h90);
    flush = 1'b1;
    step();
    flush = 1'b0;
    @(negedge clk);
    chk("flush_held_valid", 32'(bus.out_valid), 32'd0);
    step();
    bus.out_ready = 1'b1;
    repeat (4) step();

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule
